// File: rtl/div_ctrl.sv
// Multi-cycle restoring divide sequencer for DIV/DIVU in the EX stage.
// One quotient bit per cycle, sign fix-up on the final edge, result held until EX drops start.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  state_t      state_r, state_next_s;
  logic [5:0]  cnt_r, cnt_next_s;
  logic [31:0] rem_r, rem_next_s;
  logic [31:0] dvd_r, dvd_next_s;
  logic [31:0] dvs_r, dvs_next_s;
  logic        neg_quo_r, neg_quo_next_s;
  logic        neg_rem_r, neg_rem_next_s;
  logic [63:0] result_r, result_next_s;
  logic        ready_r, ready_next_s;

  // The shifted partial remainder can reach 33 bits; the true difference always fits in 32.
  logic [32:0] shifted_hi_s;
  logic        keep_s;
  logic [31:0] diff_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  assign shifted_hi_s = {rem_r, dvd_r[31]};
  assign keep_s       = (shifted_hi_s >= {1'b0, dvs_r});
  assign diff_s       = shifted_hi_s[31:0] - dvs_r;
  assign quo_fix_s    = neg_quo_r ? neg32(dvd_r) : dvd_r;
  assign rem_fix_s    = neg_rem_r ? neg32(rem_r) : rem_r;

  // Next-state and datapath update for the divide sequencer.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    rem_next_s     = rem_r;
    dvd_next_s     = dvd_r;
    dvs_next_s     = dvs_r;
    neg_quo_next_s = neg_quo_r;
    neg_rem_next_s = neg_rem_r;
    result_next_s  = result_r;
    ready_next_s   = ready_r;

    case (state_r)
      ST_FREE: begin
        result_next_s = 64'd0;
        ready_next_s  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_next_s = ST_BYZERO;
          end else begin
            state_next_s   = ST_ON;
            cnt_next_s     = 6'd0;
            rem_next_s     = 32'd0;
            dvd_next_s     = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
            dvs_next_s     = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
            neg_quo_next_s = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_next_s = signed_div_i && opdata1_i[31];
          end
        end else begin
          state_next_s = ST_FREE;
        end
      end
      ST_BYZERO: begin
        if (annul_i) begin
          state_next_s  = ST_FREE;
          cnt_next_s    = 6'd0;
          result_next_s = 64'd0;
          ready_next_s  = 1'b0;
        end else begin
          state_next_s  = ST_END;
          result_next_s = 64'd0;
          ready_next_s  = 1'b1;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_next_s  = ST_FREE;
          cnt_next_s    = 6'd0;
          result_next_s = 64'd0;
          ready_next_s  = 1'b0;
        end else if (cnt_r < 6'd32) begin
          rem_next_s = keep_s ? diff_s : shifted_hi_s[31:0];
          dvd_next_s = {dvd_r[30:0], keep_s};
          cnt_next_s = cnt_r + 6'd1;
        end else begin
          state_next_s  = ST_END;
          result_next_s = {rem_fix_s, quo_fix_s};
          ready_next_s  = 1'b1;
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_next_s  = ST_FREE;
          result_next_s = 64'd0;
          ready_next_s  = 1'b0;
        end else begin
          state_next_s = ST_END;
        end
      end
      default: begin
        state_next_s  = ST_FREE;
        cnt_next_s    = 6'd0;
        result_next_s = 64'd0;
        ready_next_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FREE;
      cnt_r     <= 6'd0;
      rem_r     <= 32'd0;
      dvd_r     <= 32'd0;
      dvs_r     <= 32'd0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_r  <= 64'd0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      rem_r     <= rem_next_s;
      dvd_r     <= dvd_next_s;
      dvs_r     <= dvs_next_s;
      neg_quo_r <= neg_quo_next_s;
      neg_rem_r <= neg_rem_next_s;
      result_r  <= result_next_s;
      ready_r   <= ready_next_s;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, results, hold/release,
// annul, reset mid-operation, divide by zero, overflow and back-to-back starts.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total_cnt;
  int bad_cnt;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op with start held; the first tick is the accept edge E0.
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    lat = -1;
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      // operand changes while busy must be ignored
      opdata1_i = 32'h1234_5678;
      opdata2_i = 32'h0000_0005;
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_res"}, result_o, exp);
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check_val({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
    check_val({tag, "_hold_res"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check_val({tag, "_rel_rdy"}, {63'd0, ready_o}, 64'd0);
    check_val({tag, "_rel_res"}, result_o, 64'd0);
  endtask

  initial begin
    int rdy_seen;
    total_cnt    = 0;
    bad_cnt      = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check_val("rst_rdy", {63'd0, ready_o}, 64'd0);
    check_val("rst_res", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_op("div_by0", 1'b1, 32'd123, 32'd0, 64'h0, 1);
    run_op("divu_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);

    // start with annul in Free is ignored
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    rdy_seen     = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) rdy_seen++;
    end
    check_val("annul_free_rdy", 64'(rdy_seen), 64'd0);

    // DIVU 1000/3 annulled at E10
    annul_i  = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ready_o) rdy_seen++;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check_val("annul_res", result_o, 64'd0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) rdy_seen++;
    end
    check_val("annul_never_rdy", 64'(rdy_seen), 64'd0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // reset at E20 of DIVU 50000/13, start held through and after reset
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50000;
    opdata2_i    = 32'd13;
    start_i      = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    rst     = 1'b1;
    annul_i = 1'b1;
    tick();
    rst     = 1'b0;
    annul_i = 1'b0;
    check_val("rst_mid_rdy", {63'd0, ready_o}, 64'd0);
    check_val("rst_mid_res", result_o, 64'd0);
    run_op("divu_after_rst", 1'b0, 32'd50000, 32'd13, 64'h00000002_00000F06, 33);

    // overflow, then a one-cycle start drop before the next op
    run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_op("div_b2b", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
